// File: rtl/qoa_slice_decoder.sv
// Mono QOA slice decoder: loads a per-frame LMS state, then turns 8-byte slices
// into 20 signed 16-bit PCM samples each, one shared multiplier for prediction.
module qoa_slice_decoder #(
    parameter int FRAME_SLICES = 256,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        LOAD_LMS,
        LOAD_SLICE,
        PREDICT,
        RECON,
        OUTPUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(FRAME_SLICES - 1);

    state_t state_reg, state_next;

    logic               ready_en_reg;
    logic [3:0]         byte_cnt_reg;
    logic [CNT_W-1:0]   slice_cnt_reg;
    logic [4:0]         k_reg;
    logic [1:0]         pcnt_reg;
    logic [63:0]        slice_reg;
    logic signed [15:0] history_reg [4];
    logic signed [15:0] weights_reg [4];
    logic signed [31:0] acc_reg;
    logic signed [15:0] r_reg;
    logic [15:0]        out_sample_reg;
    logic               out_valid_reg;

    logic               in_xfer;
    logic               out_fire;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic [5:0]         q_shift;
    logic [2:0]         q_sel;
    logic signed [15:0] r_val;
    logic signed [17:0] sum18;
    logic [15:0]        s_val;
    logic signed [15:0] delta;
    logic signed [15:0] weight_upd [4];
    logic signed [15:0] hist_shift [4];

    // Dequantisation ROM: 4 magnitudes per scale factor, odd q selects the negative entry.
    function automatic logic signed [15:0] dequant(input logic [3:0] sf, input logic [2:0] q);
        logic [59:0] row;
        logic [14:0] mag;
        case (sf)
            4'd0:    row = {15'd1,    15'd3,    15'd5,    15'd7};
            4'd1:    row = {15'd5,    15'd18,   15'd32,   15'd49};
            4'd2:    row = {15'd16,   15'd53,   15'd95,   15'd147};
            4'd3:    row = {15'd34,   15'd113,  15'd203,  15'd315};
            4'd4:    row = {15'd63,   15'd210,  15'd378,  15'd588};
            4'd5:    row = {15'd104,  15'd345,  15'd621,  15'd966};
            4'd6:    row = {15'd158,  15'd528,  15'd950,  15'd1477};
            4'd7:    row = {15'd228,  15'd760,  15'd1368, 15'd2128};
            4'd8:    row = {15'd316,  15'd1053, 15'd1895, 15'd2947};
            4'd9:    row = {15'd422,  15'd1405, 15'd2529, 15'd3934};
            4'd10:   row = {15'd548,  15'd1828, 15'd3290, 15'd5117};
            4'd11:   row = {15'd696,  15'd2320, 15'd4176, 15'd6496};
            4'd12:   row = {15'd868,  15'd2893, 15'd5207, 15'd8099};
            4'd13:   row = {15'd1064, 15'd3548, 15'd6386, 15'd9933};
            4'd14:   row = {15'd1286, 15'd4288, 15'd7718, 15'd12005};
            default: row = {15'd1536, 15'd5120, 15'd9216, 15'd14336};
        endcase
        case (q[2:1])
            2'd0:    mag = row[59:45];
            2'd1:    mag = row[44:30];
            2'd2:    mag = row[29:15];
            default: mag = row[14:0];
        endcase
        return q[0] ? 16'd0 - {1'b0, mag} : {1'b0, mag};
    endfunction

    assign in_xfer    = in_valid & in_ready;
    assign out_fire   = out_valid_reg & out_ready;
    assign out_sample = out_sample_reg;
    assign out_valid  = out_valid_reg;

    always_comb begin
        mul_a   = history_reg[pcnt_reg];
        mul_b   = weights_reg[pcnt_reg];
        prod    = {{16{mul_a[15]}}, mul_a} * {{16{mul_b[15]}}, mul_b};
        q_shift = 6'(k_reg) * 6'd3;
        q_sel   = 3'(slice_reg >> (6'd57 - q_shift));
        r_val   = dequant(slice_reg[63:60], q_sel);
        // acc[30:13] is the low 18 bits of acc >>> 13; the sum is clamped in 18 bits.
        sum18   = acc_reg[30:13] + {{2{r_val[15]}}, r_val};
        if (sum18 > 18'sd32767)
            s_val = 16'h7fff;
        else if (sum18 < -18'sd32768)
            s_val = 16'h8000;
        else
            s_val = sum18[15:0];
        delta   = r_reg >>> 4;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign weight_upd[gi] = weights_reg[gi] + (history_reg[gi][15] ? -delta : delta);
            if (gi < 3) begin : g_mid
                assign hist_shift[gi] = history_reg[gi+1];
            end else begin : g_top
                assign hist_shift[gi] = out_sample_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= LOAD_LMS;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD_LMS:   if (in_xfer && byte_cnt_reg == 4'd15) state_next = LOAD_SLICE;
            LOAD_SLICE: if (in_xfer && byte_cnt_reg == 4'd7)  state_next = PREDICT;
            PREDICT:    if (pcnt_reg == 2'd3) state_next = RECON;
            RECON:      state_next = OUTPUT;
            OUTPUT: begin
                if (out_fire) begin
                    if (k_reg != 5'd19)
                        state_next = PREDICT;
                    else if (slice_cnt_reg == LAST_SLICE)
                        state_next = LOAD_LMS;
                    else
                        state_next = LOAD_SLICE;
                end
            end
            default:    state_next = LOAD_LMS;
        endcase
        if (new_frame)
            state_next = LOAD_LMS;
    end

    always_comb begin
        in_ready = ready_en_reg & (state_reg == LOAD_LMS || state_reg == LOAD_SLICE);
        busy     = !(state_reg == LOAD_LMS && byte_cnt_reg == 4'd0);
    end

    // new_frame behaves like reset except that the last sample stays visible.
    always_ff @(posedge clk) begin
        if (rst || new_frame) begin
            ready_en_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
            slice_cnt_reg <= '0;
            k_reg         <= '0;
            pcnt_reg      <= '0;
            slice_reg     <= '0;
            acc_reg       <= '0;
            r_reg         <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                history_reg[i] <= '0;
                weights_reg[i] <= '0;
            end
            if (rst)
                out_sample_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                LOAD_LMS: begin
                    if (in_xfer) begin
                        for (int i = 0; i < 4; i++) begin
                            if (byte_cnt_reg[2:1] == 2'(i)) begin
                                if (!byte_cnt_reg[3] && !byte_cnt_reg[0]) history_reg[i][15:8] <= in_data;
                                if (!byte_cnt_reg[3] &&  byte_cnt_reg[0]) history_reg[i][7:0]  <= in_data;
                                if ( byte_cnt_reg[3] && !byte_cnt_reg[0]) weights_reg[i][15:8] <= in_data;
                                if ( byte_cnt_reg[3] &&  byte_cnt_reg[0]) weights_reg[i][7:0]  <= in_data;
                            end
                        end
                        byte_cnt_reg <= byte_cnt_reg + 4'd1;
                    end
                end
                LOAD_SLICE: begin
                    if (in_xfer) begin
                        slice_reg <= {slice_reg[55:0], in_data};
                        if (byte_cnt_reg == 4'd7) begin
                            byte_cnt_reg <= '0;
                            k_reg        <= '0;
                            pcnt_reg     <= '0;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        end
                    end
                end
                PREDICT: begin
                    acc_reg  <= ((pcnt_reg == 2'd0) ? 32'sd0 : acc_reg) + prod;
                    pcnt_reg <= pcnt_reg + 2'd1;
                end
                RECON: begin
                    out_sample_reg <= s_val;
                    out_valid_reg  <= 1'b1;
                    r_reg          <= r_val;
                end
                OUTPUT: begin
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            weights_reg[i] <= weight_upd[i];
                            history_reg[i] <= hist_shift[i];
                        end
                        if (k_reg != 5'd19) begin
                            k_reg <= k_reg + 5'd1;
                        end else begin
                            k_reg         <= '0;
                            slice_cnt_reg <= (slice_cnt_reg == LAST_SLICE) ? '0 : slice_cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qoa_slice_decoder.sv
// Directed bench for qoa_slice_decoder with a two-slice frame: reset, decode,
// clamp, LMS update, backpressure, frame wrap and abort.
module tb_qoa_slice_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_frame = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sample = 0;

    qoa_slice_decoder #(.FRAME_SLICES(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .new_frame  (new_frame),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_lms(input logic [127:0] v);
        for (int i = 0; i < 16; i++) send_byte(8'(v >> (120 - 8*i)));
    endtask

    task automatic send_slice(input logic [63:0] sl);
        for (int i = 0; i < 8; i++) send_byte(8'(sl >> (56 - 8*i)));
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("out_valid_wait", out_valid, 1);
    endtask

    task automatic get_sample(output logic [15:0] s);
        out_ready = 1'b1;
        wait_valid();
        s = out_sample;
        $display("sample %0d value=%0d", n_sample, $signed(s));
        n_sample++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] mk_slice(input logic [3:0] sf, input logic [2:0] q0, input logic [2:0] qr);
        logic [63:0] sl;
        sl = {sf, 60'd0};
        for (int k = 0; k < 20; k++) sl = sl | (64'((k == 0) ? q0 : qr) << (57 - 3*k));
        return sl;
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        stable;
        int          cyc;
        logic [15:0] w_exp [5];
        w_exp = '{16'd18, 16'd6, 16'd5, 16'd3, 16'd4};

        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sample", out_sample, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 check_eq("post_rst_in_ready_low", in_ready, 0);
        @(negedge clk);
        check_eq("post_rst_in_ready_high", in_ready, 1);

        // All-zero state and slice: every sample is the q=0, sf=0 entry (+1).
        send_lms(128'h0);
        send_slice(64'h0);
        for (int i = 0; i < 20; i++) begin
            get_sample(s);
            check_eq($sformatf("basic_s%0d", i), s, 16'd1);
        end
        check_eq("basic_next_in_ready", in_ready, 1);
        check_eq("basic_next_busy", busy, 1);

        // Second slice closes the two-slice frame.
        send_slice(64'h0);
        for (int i = 0; i < 20; i++) begin
            get_sample(s);
            check_eq($sformatf("wrap_s%0d", i), s, 16'd1);
        end
        check_eq("wrap_in_ready", in_ready, 1);
        check_eq("wrap_busy", busy, 0);

        // Fresh LMS load right after the wrap: history=-100,16000x3, weights=0.
        send_lms({16'hff9c, 16'd16000, 16'd16000, 16'd16000, 64'h0});
        send_slice(mk_slice(4'd1, 3'd2, 3'd0));
        get_sample(s);
        check_eq("wt_s0", s, w_exp[0]);

        // Hold the second sample for 50 cycles.
        out_ready = 1'b0;
        wait_valid();
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_sample !== w_exp[1] || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check_eq("bp_stable", stable, 1);
        check_eq("wt_s1", out_sample, w_exp[1]);
        $display("sample %0d value=%0d", n_sample, $signed(out_sample));
        n_sample++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_single_xfer", out_valid, 0);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("bp_next_latency", cyc, 6);
        for (int i = 2; i < 5; i++) begin
            get_sample(s);
            check_eq($sformatf("wt_s%0d", i), s, w_exp[i]);
        end
        for (int i = 5; i < 20; i++) get_sample(s);

        // Abort three bytes into a slice with a byte offered in the same cycle.
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        in_data   = 8'hAA;
        in_valid  = 1'b1;
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        in_valid  = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_in_ready", in_ready, 0);

        // Clamp: history 32767 x4, weights 0,0,0,8192, all q=6 (+7).
        send_lms({16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h0, 16'h0, 16'h0, 16'h2000});
        send_slice(mk_slice(4'd0, 3'd6, 3'd6));
        for (int i = 0; i < 20; i++) begin
            get_sample(s);
            check_eq($sformatf("clamp_s%0d", i), s, 16'h7fff);
        end

        // Reset while a sample waits in OUTPUT.
        send_slice(mk_slice(4'd0, 3'd6, 3'd6));
        out_ready = 1'b0;
        wait_valid();
        check_eq("pre_rst_sample", out_sample, 16'h7fff);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_sample", out_sample, 0);
        check_eq("mid_rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
